// File: rtl/reg_writeback.sv
// reg_writeback -- writeback issue unit driving the register-file write port.
//
// Completed ALU/memory results are queued in a DEPTH-entry FIFO. The data
// source (ALU vs memory) is chosen when an entry is accepted. At most one
// entry is popped per cycle into registered outputs, so writeReg/writeData/
// RegWrite are stable for a register file that captures on negedge CLK.
// Writes to $0 and entries with in_regwrite=0 still consume an issue slot
// but drive RegWrite=0.
//
// Parameters:
//   DEPTH  FIFO entries, power of two, 2..8
//   CNT_W  width of wb_count
//
// Ports:
//   CLK            in   single clock, all state updates on posedge
//   MasterReset_L  in   synchronous active-low reset
//   in_valid       in   producer offers a result
//   in_ready       out  unit can accept (transfer on in_valid && in_ready)
//   in_dest        in   destination register number
//   in_alu         in   ALU result
//   in_mem         in   memory load data
//   in_memtoreg    in   1: store in_mem, 0: store in_alu
//   in_regwrite    in   entry performs a register write
//   wb_hold        in   freeze issue; accepts continue while not full
//   writeReg       out  register-file write address
//   writeData      out  register-file write data
//   RegWrite       out  register-file write enable
//   wb_count       out  saturating count of issued writes with RegWrite=1
//   wb_empty       out  FIFO empty and no write being driven
//
// Optional feature (macro WB_BYPASS_EN): adds fwd_src/fwd_hit/fwd_data, a
// combinational lookup of the youngest pending write to fwd_src among the
// FIFO entries and the output registers.

module reg_writeback #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              MasterReset_L,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_dest,
  input  logic [31:0]       in_alu,
  input  logic [31:0]       in_mem,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic              wb_hold,
`ifdef WB_BYPASS_EN
  input  logic [4:0]        fwd_src,
  output logic              fwd_hit,
  output logic [31:0]       fwd_data,
`endif
  output logic [4:0]        writeReg,
  output logic [31:0]       writeData,
  output logic              RegWrite,
  output logic [CNT_W-1:0]  wb_count,
  output logic              wb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [4:0]       dest_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic             we_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic push;
  logic pop;

  // Ready depends only on current occupancy: a same-cycle pop never frees
  // room for a push, which keeps in_ready free of any path from wb_hold.
  assign in_ready = MasterReset_L && (occ < OCC_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (occ != '0) && !wb_hold;
  assign wb_empty = (occ == '0) && !RegWrite;

  // Entry storage carries no reset; occupancy decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      dest_mem[wr_ptr] <= in_dest;
      data_mem[wr_ptr] <= in_memtoreg ? in_mem : in_alu;
      we_mem[wr_ptr]   <= in_regwrite && (in_dest != 5'd0);
    end
  end

  always_ff @(posedge CLK) begin
    if (!MasterReset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      writeReg  <= '0;
      writeData <= '0;
      RegWrite  <= 1'b0;
      wb_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        writeReg  <= dest_mem[rd_ptr];
        writeData <= data_mem[rd_ptr];
        RegWrite  <= we_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        if (we_mem[rd_ptr] && (wb_count != '1)) begin
          wb_count <= wb_count + 1'b1;
        end
      end else begin
        RegWrite <= 1'b0;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so later matches override earlier ones; the
  // output registers are older than every queued entry, so they go first.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (fwd_src != 5'd0) begin
      if (RegWrite && (writeReg == fwd_src)) begin
        fwd_hit  = 1'b1;
        fwd_data = writeData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PTR_W'(i);
        if ((OCC_W'(i) < occ) && we_mem[idx] && (dest_mem[idx] == fwd_src)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem[idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  logic        CLK;
  logic        MasterReset_L;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_dest;
  logic [31:0] in_alu;
  logic [31:0] in_mem;
  logic        in_memtoreg;
  logic        in_regwrite;
  logic        wb_hold;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        RegWrite;
  logic [15:0] wb_count;
  logic        wb_empty;
`ifdef WB_BYPASS_EN
  logic [4:0]  fwd_src;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  reg_writeback #(.DEPTH(2), .CNT_W(16)) dut (
    .CLK           (CLK),
    .MasterReset_L (MasterReset_L),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dest       (in_dest),
    .in_alu        (in_alu),
    .in_mem        (in_mem),
    .in_memtoreg   (in_memtoreg),
    .in_regwrite   (in_regwrite),
    .wb_hold       (wb_hold),
`ifdef WB_BYPASS_EN
    .fwd_src       (fwd_src),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
`endif
    .writeReg      (writeReg),
    .writeData     (writeData),
    .RegWrite      (RegWrite),
    .wb_count      (wb_count),
    .wb_empty      (wb_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one posedge and settle; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [4:0] d, input logic [31:0] a, input logic [31:0] m,
                       input logic mtr, input logic rw);
    in_valid    = 1'b1;
    in_dest     = d;
    in_alu      = a;
    in_mem      = m;
    in_memtoreg = mtr;
    in_regwrite = rw;
  endtask

  task automatic test_reset();
    MasterReset_L = 1'b0;
    offer(5'd3, 32'h1, 32'h2, 1'b0, 1'b1);
    tick();
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
    total++; if (wb_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
    total++; if (wb_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", wb_empty); end
    total++; if (writeReg !== 5'd0 || writeData !== 32'd0) begin bad++; $display("FAIL reset_outregs got=%0d/%h exp=0/0", writeReg, writeData); end
    in_valid = 1'b0;
    MasterReset_L = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    offer(5'd5, 32'h1234, 32'hFFFF_0000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    total++; if (RegWrite !== 1'b0 || wb_empty !== 1'b0) begin bad++; $display("FAIL single_queued got=rw%b/empty%b exp=rw0/empty0", RegWrite, wb_empty); end
    tick();
    total++; if (RegWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'h1234) begin bad++; $display("FAIL single_issue got=%b/%0d/%h exp=1/5/00001234", RegWrite, writeReg, writeData); end
    tick();
    total++; if (RegWrite !== 1'b0 || writeReg !== 5'd5) begin bad++; $display("FAIL single_after got=%b/%0d exp=0/5", RegWrite, writeReg); end
    total++; if (wb_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", wb_count); end
    total++; if (wb_empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b exp=1", wb_empty); end
  endtask

  task automatic test_mux_zero();
    offer(5'd0, 32'h55, 32'h66, 1'b0, 1'b1);
    tick();
    offer(5'd7, 32'h1111, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    total++; if (RegWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'h55) begin bad++; $display("FAIL zero_slot got=%b/%0d/%h exp=0/0/00000055", RegWrite, writeReg, writeData); end
    tick();
    total++; if (RegWrite !== 1'b1 || writeReg !== 5'd7 || writeData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mem_slot got=%b/%0d/%h exp=1/7/deadbeef", RegWrite, writeReg, writeData); end
    tick();
    total++; if (wb_count !== 16'd2) begin bad++; $display("FAIL mux_count got=%0d exp=2", wb_count); end
  endtask

  task automatic test_full_hold();
    wb_hold = 1'b1;
    offer(5'd1, 32'hA1, 32'h0, 1'b0, 1'b1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_ready0 got=%b exp=1", in_ready); end
    tick();
    offer(5'd2, 32'hB2, 32'h0, 1'b0, 1'b1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_ready1 got=%b exp=1", in_ready); end
    tick();
    offer(5'd3, 32'hC3, 32'h0, 1'b0, 1'b1);
    total++; if (in_ready !== 1'b0 || RegWrite !== 1'b0) begin bad++; $display("FAIL full_ready got=%b/rw%b exp=0/rw0", in_ready, RegWrite); end
    tick();
    total++; if (in_ready !== 1'b0 || RegWrite !== 1'b0) begin bad++; $display("FAIL full_stay got=%b/rw%b exp=0/rw0", in_ready, RegWrite); end
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    tick();
    total++; if (RegWrite !== 1'b1 || writeReg !== 5'd1 || writeData !== 32'hA1) begin bad++; $display("FAIL drain_a got=%b/%0d/%h exp=1/1/000000a1", RegWrite, writeReg, writeData); end
    tick();
    total++; if (RegWrite !== 1'b1 || writeReg !== 5'd2 || writeData !== 32'hB2) begin bad++; $display("FAIL drain_b got=%b/%0d/%h exp=1/2/000000b2", RegWrite, writeReg, writeData); end
    tick();
    total++; if (RegWrite !== 1'b0 || wb_empty !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL drained got=rw%b/empty%b/ready%b exp=0/1/1", RegWrite, wb_empty, in_ready); end
    total++; if (wb_count !== 16'd4) begin bad++; $display("FAIL hold_count got=%0d exp=4", wb_count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      offer(5'(10 + i), 32'h100 + 32'(i), 32'h0, 1'b0, 1'b1);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
      tick();
      if (i >= 1) begin
        total++;
        if (RegWrite !== 1'b1 || writeReg !== 5'(9 + i) || writeData !== 32'hFF + 32'(i)) begin
          bad++; $display("FAIL b2b_issue%0d got=%b/%0d/%h exp=1/%0d/%h", i - 1, RegWrite, writeReg, writeData, 9 + i, 32'hFF + 32'(i));
        end
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (RegWrite !== 1'b1 || writeReg !== 5'd13 || writeData !== 32'h103) begin bad++; $display("FAIL b2b_last got=%b/%0d/%h exp=1/13/00000103", RegWrite, writeReg, writeData); end
    tick();
    total++; if (wb_count !== 16'd8 || wb_empty !== 1'b1) begin bad++; $display("FAIL b2b_count got=%0d/empty%b exp=8/1", wb_count, wb_empty); end
  endtask

  task automatic test_reset_mid();
    wb_hold = 1'b1;
    offer(5'd4, 32'h44, 32'h0, 1'b0, 1'b1);
    tick();
    offer(5'd6, 32'h66, 32'h0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    MasterReset_L = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", in_ready); end
    tick();
    MasterReset_L = 1'b1;
    total++; if (wb_empty !== 1'b1 || wb_count !== 16'd0) begin bad++; $display("FAIL mid_empty got=%b/%0d exp=1/0", wb_empty, wb_count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (RegWrite !== 1'b0 || wb_empty !== 1'b1) begin bad++; $display("FAIL mid_nowrite%0d got=rw%b/empty%b exp=0/1", i, RegWrite, wb_empty); end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    wb_hold = 1'b1;
    fwd_src = 5'd9;
    offer(5'd9, 32'd1, 32'h0, 1'b0, 1'b1);
    tick();
    offer(5'd9, 32'd2, 32'h0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd2) begin bad++; $display("FAIL fwd_young got=%b/%h exp=1/00000002", fwd_hit, fwd_data); end
    fwd_src = 5'd0;
    #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin bad++; $display("FAIL fwd_zero got=%b/%h exp=0/0", fwd_hit, fwd_data); end
    fwd_src = 5'd8;
    #1;
    total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_miss got=%b exp=0", fwd_hit); end
    wb_hold = 1'b0;
    fwd_src = 5'd9;
    tick();
    tick();
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd2) begin bad++; $display("FAIL fwd_outreg got=%b/%h exp=1/00000002", fwd_hit, fwd_data); end
    tick();
    total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_gone got=%b exp=0", fwd_hit); end
  endtask
`endif

  initial begin
    MasterReset_L = 1'b0;
    in_valid      = 1'b0;
    in_dest       = '0;
    in_alu        = '0;
    in_mem        = '0;
    in_memtoreg   = 1'b0;
    in_regwrite   = 1'b0;
    wb_hold       = 1'b0;
`ifdef WB_BYPASS_EN
    fwd_src       = '0;
`endif
    test_reset();
    test_single();
    test_mux_zero();
    test_full_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
